// File: rtl/zuc_keystream_xor.sv
// zuc_keystream_xor
//   Final stage of the cipher core. It XORs the 32-bit ZUC keystream (from the
//   keystream register-slice chain) with the message word stream. Per message
//   it accepts one bit-length command, joins exactly ceil(len/32) word pairs,
//   and flags the final word with m_last.
//
//   Optional feature macro: ZUC_KSXOR_TAIL_MASK_EN
//     defined   : the lower 32-len[4:0] bits of the final word are zeroed
//                 (only when len[4:0] != 0).
//     undefined : the final word is the full, unmasked 32-bit XOR.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_cmd_valid/ready/len         message length command, in bits
//   s_ks_valid/ready/data         keystream words
//   s_msg_valid/ready/data        message words; the MSB is the first stream bit
//   m_valid/ready/data/last       result words; m_last marks the final word
//   busy                          high while a message is running or output is pending
module zuc_keystream_xor #(
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_cmd_valid,
  output logic             s_cmd_ready,
  input  logic [LEN_W-1:0] s_cmd_len,
  input  logic             s_ks_valid,
  output logic             s_ks_ready,
  input  logic [31:0]      s_ks_data,
  input  logic             s_msg_valid,
  output logic             s_msg_ready,
  input  logic [31:0]      s_msg_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-5:0] words_left, words_left_nxt;
  logic [LEN_W-5:0] cmd_words;
  logic             cmd_fire;
  logic             out_free;
  logic             fire;
  logic             last_word;
  logic [31:0]      xor_word;
  logic [31:0]      result;

  // ceil(len/32) without forming len+31, so that lengths near 2^LEN_W
  // cannot overflow.
  assign cmd_words = {1'b0, s_cmd_len[LEN_W-1:5]}
                   + {{(LEN_W-5){1'b0}}, |s_cmd_len[4:0]};

  assign out_free  = !m_valid || m_ready;
  assign cmd_fire  = (state == IDLE) && s_cmd_valid;
  // Both streams fire together or not at all.
  assign fire      = (state == RUN) && s_ks_valid && s_msg_valid && out_free;
  assign last_word = (words_left == (LEN_W-4)'(1));
  assign xor_word  = s_msg_data ^ s_ks_data;

`ifdef ZUC_KSXOR_TAIL_MASK_EN
  logic [4:0]  tail;
  logic [31:0] tail_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
    end else if (cmd_fire) begin
      tail <= s_cmd_len[4:0];
    end
  end

  // Keeps the upper 'tail' bits: the first stream bits live at the MSB end.
  assign tail_mask = ~(32'hFFFF_FFFF >> tail);

  always_comb begin
    result = xor_word;
    if (last_word && (tail != 5'd0)) begin
      result = xor_word & tail_mask;
    end
  end
`else
  always_comb begin
    result = xor_word;
  end
`endif

  // State and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      words_left <= '0;
    end else begin
      state      <= state_nxt;
      words_left <= words_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    words_left_nxt = words_left;
    s_cmd_ready    = 1'b0;
    s_ks_ready     = 1'b0;
    s_msg_ready    = 1'b0;
    unique case (state)
      IDLE: begin
        s_cmd_ready = 1'b1;
        if (cmd_fire) begin
          words_left_nxt = cmd_words;
          // A zero-length command is accepted and dropped.
          if (cmd_words != '0) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Each ready looks only at the other stream's valid.
        s_ks_ready  = s_msg_valid && out_free;
        s_msg_ready = s_ks_valid && out_free;
        if (fire) begin
          words_left_nxt = words_left - (LEN_W-4)'(1);
          if (last_word) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output register: a new word may replace a draining one in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (fire) begin
      m_valid <= 1'b1;
      m_data  <= result;
      m_last  <= last_word;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  assign busy = (state == RUN) || m_valid;

endmodule

// File: tb/tb_zuc_keystream_xor.sv
// Self-checking bench for zuc_keystream_xor: directed steps plus randomized
// messages, checked against a word-list reference model.
module tb_zuc_keystream_xor;

  logic        clk;
  logic        rst;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [31:0] s_cmd_len;
  logic        s_ks_valid;
  logic        s_ks_ready;
  logic [31:0] s_ks_data;
  logic        s_msg_valid;
  logic        s_msg_ready;
  logic [31:0] s_msg_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] ks_mem  [0:17];
  logic [31:0] msg_mem [0:17];

`ifdef ZUC_KSXOR_TAIL_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  zuc_keystream_xor #(.LEN_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_cmd_valid (s_cmd_valid),
    .s_cmd_ready (s_cmd_ready),
    .s_cmd_len   (s_cmd_len),
    .s_ks_valid  (s_ks_valid),
    .s_ks_ready  (s_ks_ready),
    .s_ks_data   (s_ks_data),
    .s_msg_valid (s_msg_valid),
    .s_msg_ready (s_msg_ready),
    .s_msg_data  (s_msg_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Runs one message. The model is a list of expected result words plus the
  // single pending output word; all checks happen 2 time units after a clock edge.
  task automatic run_msg(input logic [31:0] len, input int unsigned ks_skew,
                         input bit gaps, input int unsigned mr_mode);
    logic [31:0] exp_w [$];
    logic [31:0] d, pend_d;
    logic        pend_l, mv, run, ksv, msv, mr, fire, free;
    int unsigned n, idx, cyc, sh;
    n = int'((64'(len) + 64'd31) / 64'd32);
    for (int unsigned i = 0; i < n; i++) begin
      d = msg_mem[i] ^ ks_mem[i];
      if (MASKED && (i == n - 1) && (len % 32 != 0)) begin
        sh = 32 - (len % 32);
        d  = (d >> sh) << sh;
      end
      exp_w.push_back(d);
    end
    // command handshake, both streams offered to show nothing is taken in IDLE
    s_cmd_valid = 1'b1;
    s_cmd_len   = len;
    s_ks_valid  = 1'b1;
    s_msg_valid = 1'b1;
    s_ks_data   = ks_mem[0];
    s_msg_data  = msg_mem[0];
    m_ready     = 1'b1;
    #1;
    chk("cmd_ready_idle", 32'(s_cmd_ready), 32'd1);
    chk("ks_ready_idle", 32'(s_ks_ready), 32'd0);
    chk("msg_ready_idle", 32'(s_msg_ready), 32'd0);
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    run = (n != 0);
    mv = 1'b0; pend_d = '0; pend_l = 1'b0;
    idx = 0; cyc = 0;
    while ((run || mv) && cyc < 600) begin
      ksv = (cyc >= ks_skew) && (!gaps || $urandom_range(0, 3) != 0);
      msv = !gaps || ($urandom_range(0, 3) != 0);
      case (mr_mode)
        0:       mr = 1'b1;
        1:       mr = (cyc % 3 == 0);
        default: mr = ($urandom_range(0, 2) != 0);
      endcase
      s_ks_valid  = ksv;
      s_msg_valid = msv;
      s_ks_data   = ks_mem[idx];
      s_msg_data  = msg_mem[idx];
      m_ready     = mr;
      #1;
      free = !mv || mr;
      chk("m_valid", 32'(m_valid), 32'(mv));
      if (mv) begin
        chk("m_data", m_data, pend_d);
        chk("m_last", 32'(m_last), 32'(pend_l));
      end
      chk("busy", 32'(busy), 32'(run || mv));
      chk("cmd_ready", 32'(s_cmd_ready), 32'(!run));
      chk("ks_ready", 32'(s_ks_ready), 32'(run && msv && free));
      chk("msg_ready", 32'(s_msg_ready), 32'(run && ksv && free));
      fire = run && ksv && msv && free;
      @(posedge clk); #1;
      if (fire) begin
        mv     = 1'b1;
        pend_d = exp_w[idx];
        pend_l = (idx == n - 1);
        idx++;
        if (idx == n) run = 1'b0;
      end else if (mr) begin
        mv = 1'b0;
      end
      cyc++;
    end
    chk("words_done", idx, n);
    // idle afterwards: excess words are offered but must stay upstream
    s_ks_valid  = 1'b1;
    s_msg_valid = 1'b1;
    m_ready     = 1'b1;
    #1;
    chk("idle_m_valid", 32'(m_valid), 32'(mv));
    chk("idle_busy", 32'(busy), 32'(mv));
    chk("idle_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("idle_ks_ready", 32'(s_ks_ready), 32'd0);
    chk("idle_msg_ready", 32'(s_msg_ready), 32'd0);
    @(posedge clk); #1;
    s_ks_valid  = 1'b0;
    s_msg_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int unsigned i = 0; i < 18; i++) begin
      ks_mem[i]  = $urandom;
      msg_mem[i] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1;
    s_cmd_valid = 1'b0; s_cmd_len = '0;
    s_ks_valid = 1'b0; s_ks_data = '0;
    s_msg_valid = 1'b0; s_msg_data = '0;
    m_ready = 1'b0;
    fill_random();

    // reset values
    @(posedge clk); #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("rst_ks_ready", 32'(s_ks_ready), 32'd0);
    chk("rst_msg_ready", 32'(s_msg_ready), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-length command: nothing consumed, nothing produced
    run_msg(32'd0, 0, 1'b0, 0);

    // len=64 directed
    ks_mem[0] = 32'hFFFF0000; ks_mem[1] = 32'h12345678;
    msg_mem[0] = 32'h0000FFFF; msg_mem[1] = 32'h12345678;
    run_msg(32'd64, 0, 1'b0, 0);

    // len=40 directed tail
    ks_mem[0] = 32'h0; ks_mem[1] = 32'h0;
    msg_mem[0] = 32'hAAAAAAAA; msg_mem[1] = 32'hDEADBEEF;
    run_msg(32'd40, 0, 1'b0, 0);

    // backpressure 1,0,0,1,...
    fill_random();
    run_msg(32'd96, 0, 1'b0, 1);

    // keystream skew of 5 cycles; a 4th ks word stays pending afterwards
    fill_random();
    run_msg(32'd96, 5, 1'b0, 0);

    // length boundaries
    fill_random(); run_msg(32'd1, 0, 1'b0, 0);
    fill_random(); run_msg(32'd31, 0, 1'b0, 2);
    fill_random(); run_msg(32'd32, 0, 1'b1, 0);
    fill_random(); run_msg(32'd33, 1, 1'b1, 2);

    // randomized messages
    for (int unsigned t = 0; t < 20; t++) begin
      fill_random();
      run_msg(32'($urandom_range(0, 480)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // asynchronous reset after the first of three words
    fill_random();
    s_cmd_valid = 1'b1; s_cmd_len = 32'd96; m_ready = 1'b1;
    s_ks_valid = 1'b0; s_msg_valid = 1'b0;
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    s_ks_valid = 1'b1; s_msg_valid = 1'b1;
    s_ks_data = ks_mem[0]; s_msg_data = msg_mem[0];
    @(posedge clk); #1;
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_m_data", m_data, ks_mem[0] ^ msg_mem[0]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_data", m_data, 32'd0);
    chk("arst_m_last", 32'(m_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("arst_ks_ready", 32'(s_ks_ready), 32'd0);
    chk("arst_msg_ready", 32'(s_msg_ready), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    s_ks_valid = 1'b0; s_msg_valid = 1'b0;
    @(posedge clk); #1;
    fill_random();
    run_msg(32'd32, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
